mem_port_arbiter: RTL and testbench



---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-port types: requester identity, arbiter states and default widths.
// Reused by the MMU, the memory model and the port arbiter.
package mem_pkg;

   localparam int unsigned MEM_AW = 64;
   localparam int unsigned MEM_DW = 64;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Two-way round-robin pick: on a tie the side not served last wins.
   function automatic owner_e rr_pick(input logic   req_if,
                                      input logic   req_d,
                                      input owner_e last_owner);
      owner_e pick;
      pick = OWN_IF;
      if (req_if && req_d) begin
         if (last_owner == OWN_IF) pick = OWN_D;
         else                      pick = OWN_IF;
      end else if (req_d) begin
         pick = OWN_D;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker holding the last-served owner.
// Shared with the data cache refill path.
module rr_arb2
   import mem_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_n_i,
   input  logic   req_if_i,
   input  logic   req_d_i,
   input  logic   update_i,
   input  owner_e served_i,
   output logic   valid_o,
   output owner_e pick_o
);

   owner_e last_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q <= OWN_IF;
      end else if (update_i) begin
         last_q <= served_i;
      end
   end

   always_comb begin
      valid_o = req_if_i | req_d_i;
      pick_o  = rr_pick(req_if_i, req_d_i, last_q);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch/page-walk and data load/store,
// one outstanding transaction, registered grant and response.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned AW = MEM_AW,
   parameter int unsigned DW = MEM_DW,
   parameter int unsigned MW = DW / 8
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,

   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic [MW-1:0] d_wmask,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [MW-1:0] mem_wmask,
   input  logic          mem_ready,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,

   output logic          busy,
   output logic          proto_err
);

   arb_state_e    state_q;
   owner_e        owner_q;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [MW-1:0] wmask_q;
   logic          mem_req_q;
   logic          if_gnt_q, d_gnt_q;
   logic          if_rvalid_q, d_rvalid_q;
   logic [DW-1:0] if_rdata_q, d_rdata_q;
   logic          busy_q;
   logic          proto_err_q;

   logic          arb_valid;
   owner_e        arb_pick;
   logic          resp_take;
   logic          stray;
   logic [DW-1:0] rdata_d;

   rr_arb2 u_rr (
      .clk_i    (clk),
      .rst_n_i  (rst),
      .req_if_i (if_req),
      .req_d_i  (d_req),
      .update_i (state_q == RESP),
      .served_i (owner_q),
      .valid_o  (arb_valid),
      .pick_o   (arb_pick)
   );

   // A completion is taken in WAIT, or in ISSUE when it coincides with ready.
   always_comb begin
      resp_take = 1'b0;
      stray     = 1'b0;
      rdata_d   = mem_rdata;
      if (we_q) rdata_d = '0;
      case (state_q)
         IDLE:    stray     = mem_rvalid;
         ISSUE: begin
            resp_take = mem_ready && mem_rvalid;
            stray     = !mem_ready && mem_rvalid;
         end
         WAIT:    resp_take = mem_rvalid;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         mem_req_q   <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;

         if (stray) proto_err_q <= 1'b1;

         if (resp_take) begin
            if (owner_q == OWN_D) begin
               d_rdata_q  <= rdata_d;
               d_rvalid_q <= 1'b1;
            end else begin
               if_rdata_q  <= rdata_d;
               if_rvalid_q <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  owner_q   <= arb_pick;
                  state_q   <= ISSUE;
                  busy_q    <= 1'b1;
                  mem_req_q <= 1'b1;
                  if (arb_pick == OWN_D) begin
                     addr_q  <= d_addr;
                     we_q    <= d_we;
                     wdata_q <= d_wdata;
                     wmask_q <= d_wmask;
                     d_gnt_q <= 1'b1;
                  end else begin
                     addr_q   <= if_addr;
                     we_q     <= 1'b0;
                     wdata_q  <= '0;
                     wmask_q  <= '0;
                     if_gnt_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  if (mem_rvalid) state_q <= RESP;
                  else            state_q <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) state_q <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_gnt     = d_gnt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign busy      = busy_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, tie/alternation,
// stray completion and reset-in-WAIT sequences, with per-side response scoreboards.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [63:0] if_rdata;
   logic        d_req, d_we;
   logic [63:0] d_addr, d_wdata;
   logic [7:0]  d_wmask;
   logic        d_gnt, d_rvalid;
   logic [63:0] d_rdata;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ready, mem_rvalid;
   logic [63:0] mem_rdata;
   logic        busy, proto_err;

   mem_port_arbiter #(.AW(64), .DW(64), .MW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_ready (mem_ready),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        side;      // 0 = fetch, 1 = data
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      int unsigned rdly;      // cycles before mem_ready
      int unsigned vdly;      // cycles from ready to rvalid (0 = same cycle)
      logic [63:0] exp_rdata;
      int unsigned exp_lat;   // gnt cycle to owner rvalid cycle
   } vec_t;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [63:0] sb_if[$];
   logic [63:0] sb_d[$];

   int unsigned mm_ready_dly = 0;
   int unsigned mm_rv_dly    = 1;
   int unsigned stray_cnt    = 0;
   int unsigned mm_req_cycles;
   logic        mm_stable;

   function automatic logic [63:0] data_of(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'hDEAD_BEEF_0000_0013;
      return {a[31:0] ^ 32'hA5A5_0000, ~a[63:32]};
   endfunction

   function automatic vec_t mk(input logic side, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wmask,
                               input int unsigned rdly, input int unsigned vdly);
      vec_t v;
      v.side  = side;
      v.we    = we;
      v.addr  = addr;
      v.wdata = wdata;
      v.wmask = wmask;
      v.rdly  = rdly;
      v.vdly  = vdly;
      v.exp_rdata = we ? 64'h0 : data_of(addr);
      v.exp_lat   = rdly + ((vdly == 0) ? 1 : vdly + 1);
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model: accepts after mm_ready_dly, completes mm_rv_dly cycles after ready.
   initial begin : mem_model
      logic [63:0] a, wd;
      logic        w;
      logic [7:0]  wm;
      int unsigned seen;
      seen = 0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      mm_req_cycles = 0; mm_stable = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stray_cnt != seen) begin
            seen = stray_cnt;
            mem_rvalid = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
         end else if (mem_req) begin
            a = mem_addr; w = mem_we; wd = mem_wdata; wm = mem_wmask;
            mm_stable = 1'b1; mm_req_cycles = 1;
            for (int i = 0; i < int'(mm_ready_dly); i++) begin
               @(posedge clk); #1;
               if (mem_req) mm_req_cycles++;
               if (!mem_req || mem_addr !== a || mem_we !== w || mem_wdata !== wd || mem_wmask !== wm)
                  mm_stable = 1'b0;
            end
            mem_ready = 1'b1;
            if (mm_rv_dly == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = w ? 64'hFFFF_0000_FFFF_0000 : data_of(a);
            end
            @(posedge clk); #1;
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (mem_req) mm_stable = 1'b0;
            if (mm_rv_dly > 0) begin
               for (int i = 1; i < int'(mm_rv_dly); i++) begin
                  @(posedge clk); #1;
               end
               mem_rvalid = 1'b1;
               mem_rdata  = w ? 64'hFFFF_0000_FFFF_0000 : data_of(a);
               @(posedge clk); #1;
               mem_rvalid = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_txn(input vec_t v);
      int unsigned t;
      logic [63:0] other;
      logic        wrong;
      mm_ready_dly = v.rdly;
      mm_rv_dly    = v.vdly;
      other = v.side ? if_rdata : d_rdata;
      wrong = 1'b0;
      @(posedge clk); #1;
      if (v.side) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
         sb_d.push_back(v.exp_rdata);
      end else begin
         if_req = 1'b1; if_addr = v.addr;
         sb_if.push_back(v.exp_rdata);
      end
      t = 0;
      do begin
         @(posedge clk); #1; t++;
         if (v.side ? if_gnt : d_gnt) wrong = 1'b1;
      end while (!(v.side ? d_gnt : if_gnt) && t < 20);
      check("gnt latency", 64'(t), 64'd1);
      check("mem_req at gnt", mem_req, 1'b1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", mem_we, v.side ? v.we : 1'b0);
      check("mem_wmask", mem_wmask, v.side ? v.wmask : 8'h00);
      if (v.side) d_req = 1'b0; else if_req = 1'b0;
      t = 0;
      do begin
         @(posedge clk); #1; t++;
         if (v.side ? (if_rvalid || if_gnt) : (d_rvalid || d_gnt)) wrong = 1'b1;
      end while (!(v.side ? d_rvalid : if_rvalid) && t < 40);
      check("rvalid latency", 64'(t), 64'(v.exp_lat));
      check("non-owner quiet", wrong, 1'b0);
      check("mem_req cycles", 64'(mm_req_cycles), 64'(v.rdly + 1));
      check("mem fields stable", mm_stable, 1'b1);
      check("non-owner rdata held", v.side ? if_rdata : d_rdata, other);
      @(posedge clk); #1;
      check("idle after resp", busy, 1'b0);
   endtask

   vec_t vecs[7];

   initial begin : main
      int unsigned t, ngnt_if, ngnt_d;
      logic        who, both;

      vecs[0] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 0, 1);
      vecs[1] = mk(1'b1, 1'b1, 64'h0000_0000_0000_1000, 64'h55, 8'h01, 3, 1);
      vecs[2] = mk(1'b1, 1'b0, 64'h0000_0000_0000_2000, 64'h0, 8'h00, 0, 0);
      vecs[3] = mk(1'b0, 1'b0, 64'h0000_0000_4000_0040, 64'h0, 8'h00, 2, 3);
      vecs[4] = mk(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, '1, 8'hFF, 1, 0);
      vecs[5] = mk(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 0, 2);
      vecs[6] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 0, 0);

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               if (if_rvalid) begin
                  if (sb_if.size() == 0) check("if_rvalid unexpected", 1'b1, 1'b0);
                  else                   check("if_rdata", if_rdata, sb_if.pop_front());
               end
               if (d_rvalid) begin
                  if (sb_d.size() == 0) check("d_rvalid unexpected", 1'b1, 1'b0);
                  else                  check("d_rdata", d_rdata, sb_d.pop_front());
               end
            end
         end
      join_none

      rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
      #1;
      check("reset ctrl outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy, proto_err}, 8'h00);
      check("reset mem_addr", mem_addr, 64'h0);
      check("reset rdata", if_rdata | d_rdata | mem_wdata, 64'h0);
      check("reset wmask", mem_wmask, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Both sides requesting from reset: data wins first, then strict alternation.
      mm_ready_dly = 0; mm_rv_dly = 1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 64'h0000_0000_8000_0100; sb_if.push_back(data_of(if_addr));
      d_req  = 1'b1; d_we = 1'b0; d_addr = 64'h0000_0000_0000_3000; sb_d.push_back(data_of(d_addr));
      ngnt_if = 0; ngnt_d = 0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         do begin @(posedge clk); #1; t++; end while (!(if_gnt || d_gnt) && t < 20);
         both = if_gnt && d_gnt;
         who  = d_gnt;
         check("tie single gnt", both, 1'b0);
         check("tie order", who, (k % 2 == 0) ? 1'b1 : 1'b0);
         check("grant interval", 64'(t), (k == 0) ? 64'd1 : 64'd4);
         if (who) begin
            ngnt_d++;
            if (ngnt_d == 1) begin d_addr = 64'h0000_0000_0000_3008; sb_d.push_back(data_of(d_addr)); end
            else d_req = 1'b0;
         end else begin
            ngnt_if++;
            if (ngnt_if == 1) begin if_addr = 64'h0000_0000_8000_0108; sb_if.push_back(data_of(if_addr)); end
            else if_req = 1'b0;
         end
      end
      t = 0;
      do begin @(posedge clk); #1; t++; end while ((busy || sb_if.size() != 0 || sb_d.size() != 0) && t < 30);
      check("tie drained", 64'(sb_if.size() + sb_d.size()), 64'd0);

      foreach (vecs[i]) do_txn(vecs[i]);

      // Completion with nothing outstanding.
      check("proto_err before stray", proto_err, 1'b0);
      @(negedge clk); stray_cnt++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("proto_err after stray", proto_err, 1'b1);
      check("no rvalid on stray", {if_rvalid, d_rvalid, busy}, 3'b000);
      do_txn(vecs[2]);
      check("proto_err sticky", proto_err, 1'b1);

      // Reset while waiting for completion; the late completion is then stray.
      mm_ready_dly = 0; mm_rv_dly = 6;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 64'h0000_0000_8000_0200;
      @(posedge clk); #1;
      check("mid-wait gnt", if_gnt, 1'b1);
      if_req = 1'b0;
      @(posedge clk); #1;
      check("in WAIT", {busy, mem_req}, 2'b10);
      #2 rst = 1'b0;
      #1;
      check("reset mid-wait ctrl", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, busy, proto_err}, 7'h00);
      check("reset mid-wait if_rdata", if_rdata, 64'h0);
      check("reset mid-wait mem_addr", mem_addr, 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!proto_err && t < 10);
      check("late rvalid proto_err", proto_err, 1'b1);
      repeat (3) @(posedge clk);
      do_txn(vecs[0]);

      @(negedge clk) rst = 1'b0;
      #1;
      check("reset clears proto_err", proto_err, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      check("sb drained", 64'(sb_if.size() + sb_d.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
